// File: rtl/ram_responder.sv
// ram_responder: single-port synchronous RAM serving controller reads and
// writes, with a boot-load FSM that fills memory from a byte stream after
// reset while holding the CPU.
// Optional feature: define RAM_WRITE_PROTECT_EN to drop RUN-mode writes below
// PROT_LIMIT and raise a sticky wp_violation flag.
module ram_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int BOOT_LOAD  = 1,
  parameter int PROT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_en,
  input  logic              ram_rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              wp_violation
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  // One extra bit so a limit equal to the full depth still compares correctly.
  localparam logic [ADDR_W:0] PROT_LIM_W = (ADDR_W + 1)'(PROT_LIMIT);
  localparam logic BOOT_EN = (BOOT_LOAD != 0);
`ifdef RAM_WRITE_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DONE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run_rd;
  logic              run_wr;
  logic              ld_wr;
  logic              wr_blocked;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Decode the single write port: loader owns it in LOAD, controller in RUN.
  always_comb begin
    run_rd     = (state == ST_RUN) && ram_en && !ram_rw;
    run_wr     = (state == ST_RUN) && ram_en && ram_rw;
    ld_wr      = (state == ST_LOAD) && ld_valid;
    wr_blocked = PROT_EN && run_wr && ({1'b0, addr} < PROT_LIM_W);
    mem_we     = !reset && (ld_wr || (run_wr && !wr_blocked));
    if (ld_wr) begin
      mem_waddr = ptr;
      mem_wdata = ld_data;
    end else begin
      mem_waddr = addr;
      mem_wdata = wdata;
    end
  end

  // Memory array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Boot-load FSM with registered handshake/hold outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT_EN ? ST_LOAD : ST_RUN;
      ptr       <= {ADDR_W{1'b0}};
      ld_ready  <= BOOT_EN;
      cpu_hold  <= BOOT_EN;
      load_done <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_valid) begin
            ptr <= ptr + 1'b1;
            // Last byte, or memory full: the pointer wraps to 0 on its own.
            if (ld_last || (ptr == PTR_MAX)) begin
              state     <= ST_DONE;
              ld_ready  <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_RUN;
          ld_ready  <= 1'b0;
          cpu_hold  <= 1'b0;
          load_done <= 1'b0;
        end
        ST_RUN: begin
          ld_ready  <= 1'b0;
          cpu_hold  <= 1'b0;
          load_done <= 1'b0;
        end
        default: begin
          state     <= ST_RUN;
          ld_ready  <= 1'b0;
          cpu_hold  <= 1'b0;
          load_done <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port: data and valid pulse one cycle after a RUN read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= {DATA_W{1'b0}};
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= run_rd;
      if (run_rd) begin
        rdata <= mem[addr];
      end
    end
  end

`ifdef RAM_WRITE_PROTECT_EN
  // Sticky flag for any RUN write aimed at the protected region.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_violation <= 1'b0;
    end else if (wr_blocked) begin
      wp_violation <= 1'b1;
    end
  end
`else
  assign wp_violation = 1'b0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: boot load, a table of RUN accesses,
// full-memory wrap, randomized RUN traffic against a memory model, mid-load
// reset and (when compiled in) write protection.
module tb_ram_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       ram_en;
  logic       ram_rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_hold;
  logic       load_done;
  logic       wp_violation;

`ifdef RAM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of expected contents plus expected outputs.
  logic [7:0] mm [256];
  logic [7:0] exp_rd;
  logic       exp_wp;

  typedef struct {
    logic       en;
    logic       rw;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rdata;
    logic       exp_v;
  } vec_t;

  vec_t tv [9];

  ram_responder #(
    .ADDR_W(8), .DATA_W(8), .BOOT_LOAD(1), .PROT_LIMIT(16)
  ) dut (
    .clk(clk), .reset(reset), .ram_en(ram_en), .ram_rw(ram_rw),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .load_done(load_done),
    .wp_violation(wp_violation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One RUN-mode access, expectation taken from the memory model.
  task automatic run_op(input logic en, input logic rw, input logic [7:0] a, input logic [7:0] d);
    logic ev;
    ram_en = en; ram_rw = rw; addr = a; wdata = d;
    ev = 1'b0;
    if (en && !rw) begin
      exp_rd = mm[a];
      ev = 1'b1;
    end
    if (en && rw) begin
      if (PROT && (a < 8'd16)) exp_wp = 1'b1;
      else mm[a] = d;
    end
    cyc();
    chk("run_rdata", rdata, exp_rd);
    chk("run_rd_valid", rd_valid, ev);
    chk("run_wp", wp_violation, exp_wp);
    ram_en = 1'b0;
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h05, 1'b1};
    tv[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h05, 1'b0};
    tv[2] = '{1'b1, 1'b1, 8'h40, 8'hA5, 8'h05, 1'b0};
    tv[3] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'hA5, 1'b1};
    tv[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h3E, 1'b1};
    tv[5] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h76, 1'b1};
    tv[6] = '{1'b1, 1'b1, 8'h82, 8'h5A, 8'h76, 1'b0};
    tv[7] = '{1'b1, 1'b0, 8'h82, 8'h00, 8'h5A, 1'b1};
    tv[8] = '{1'b0, 1'b0, 8'h82, 8'h00, 8'h5A, 1'b0};

    reset = 1'b1; ram_en = 1'b0; ram_rw = 1'b0; addr = 8'h00; wdata = 8'h00;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    exp_rd = 8'h00; exp_wp = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_wp", wp_violation, 1'b0);

    // Boot load 3E,05,76; controller strobes during LOAD must be ignored.
    ld_valid = 1'b1; ld_data = 8'h3E; ld_last = 1'b0;
    ram_en = 1'b1; ram_rw = 1'b1; addr = 8'h01; wdata = 8'hEE;
    cyc();
    chk("boot_b0_ld_ready", ld_ready, 1'b1);
    chk("boot_b0_load_done", load_done, 1'b0);
    ld_data = 8'h05; ram_rw = 1'b0;
    cyc();
    chk("boot_b1_rd_valid", rd_valid, 1'b0);
    ld_data = 8'h76; ld_last = 1'b1;
    cyc();
    chk("boot_done_pulse", load_done, 1'b1);
    chk("boot_done_ld_ready", ld_ready, 1'b0);
    chk("boot_done_cpu_hold", cpu_hold, 1'b1);
    chk("boot_done_rd_valid", rd_valid, 1'b0);
    ld_valid = 1'b0; ld_last = 1'b0; ram_en = 1'b0;
    cyc();
    chk("boot_run_load_done", load_done, 1'b0);
    chk("boot_run_cpu_hold", cpu_hold, 1'b0);

    // Table of RUN accesses with fixed expectations.
    for (int i = 0; i < 9; i++) begin
      ram_en = tv[i].en; ram_rw = tv[i].rw; addr = tv[i].a; wdata = tv[i].d;
      cyc();
      chk($sformatf("tv%0d_rdata", i), rdata, tv[i].exp_rdata);
      chk($sformatf("tv%0d_rd_valid", i), rd_valid, tv[i].exp_v);
    end
    ram_en = 1'b0;

    // Full-memory wrap: 256 bytes, no ld_last.
    reset = 1'b1;
    cyc();
    reset = 1'b0; exp_rd = 8'h00; exp_wp = 1'b0;
    chk("wrap_rst_ld_ready", ld_ready, 1'b1);
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i); ld_last = 1'b0;
      cyc();
      chk("wrap_load_done", load_done, (i == 255));
      chk("wrap_ld_ready", ld_ready, (i != 255));
      mm[i] = 8'(i);
    end
    chk("wrap_done_cpu_hold", cpu_hold, 1'b1);
    ld_data = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("wrap_after_ld_ready", ld_ready, 1'b0);
      chk("wrap_after_load_done", load_done, 1'b0);
      chk("wrap_after_cpu_hold", cpu_hold, 1'b0);
    end
    ld_valid = 1'b0;
    run_op(1'b1, 1'b0, 8'h00, 8'h00);
    run_op(1'b1, 1'b0, 8'hFF, 8'h00);

    // Randomized RUN traffic against the model.
    for (int n = 0; n < 400; n++) begin
      run_op(($urandom_range(3) != 0), $urandom_range(1) != 0,
             8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    // Mid-load reset.
    reset = 1'b1;
    cyc();
    reset = 1'b0; exp_rd = 8'h00; exp_wp = 1'b0;
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_wp", wp_violation, 1'b0);
    chk("mid_rst_cpu_hold", cpu_hold, 1'b1);
    ld_valid = 1'b1; ld_data = 8'h11;
    cyc();
    ld_data = 8'h22;
    cyc();
    mm[0] = 8'h11; mm[1] = 8'h22;
    reset = 1'b1; ld_data = 8'h33;
    cyc();
    reset = 1'b0; ld_valid = 1'b0;
    chk("mid_reload_ld_ready", ld_ready, 1'b1);
    ram_en = 1'b1; ram_rw = 1'b0; addr = 8'h02;
    cyc();
    chk("mid_load_rd_valid_a", rd_valid, 1'b0);
    ram_rw = 1'b1; addr = 8'h03; wdata = 8'hC3;
    cyc();
    chk("mid_load_rd_valid_b", rd_valid, 1'b0);
    ram_en = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h99; ld_last = 1'b1;
    cyc();
    chk("mid_load_done", load_done, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0; mm[0] = 8'h99;
    cyc();
    chk("mid_run_cpu_hold", cpu_hold, 1'b0);
    run_op(1'b1, 1'b0, 8'h00, 8'h00);
    run_op(1'b1, 1'b0, 8'h01, 8'h00);
    run_op(1'b1, 1'b0, 8'h02, 8'h00);
    run_op(1'b1, 1'b0, 8'h03, 8'h00);

    // Protected-region write (dropped only when the feature is compiled in).
    run_op(1'b1, 1'b1, 8'h05, 8'hFF);
    run_op(1'b1, 1'b0, 8'h05, 8'h00);
    chk("wp_flag_after_low_write", wp_violation, PROT);
    run_op(1'b1, 1'b1, 8'h10, 8'h77);
    run_op(1'b1, 1'b0, 8'h10, 8'h00);
    chk("wp_flag_sticky", wp_violation, PROT);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("wp_cleared_by_reset", wp_violation, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
